// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_pkg
//  Purpose  : Shared definitions for the HD44780-style 8-bit LCD bus:
//             instruction opcodes, execution-time defaults, address-counter
//             wrap points and the DDRAM address-to-index mapping.
//  Revision : 1.0  initial release
// ============================================================================
package lcd_pkg;

    // Base opcodes (leading-one position selects the instruction class).
    typedef enum logic [7:0] {
        CMD_CLEAR   = 8'h01,
        CMD_HOME    = 8'h02,
        CMD_ENTRY   = 8'h04,
        CMD_DISPCTL = 8'h08,
        CMD_SHIFT   = 8'h10,
        CMD_FUNC    = 8'h20,
        CMD_CGRAM   = 8'h40,
        CMD_DDRAM   = 8'h80
    } cmd_t;

    // Execution times in 50 MHz clock cycles.
    localparam int unsigned C_CYCLES_1530US = 76500;
    localparam int unsigned C_CYCLES_43US   = 2150;
    localparam int unsigned C_CYCLES_39US   = 1950;
    localparam int unsigned C_CYCLES_E_MIN  = 7;

    // Two-line address map: line 1 is 0x00-0x27, line 2 is 0x40-0x67.
    localparam logic [6:0] C_AC_L1_END   = 7'h27;
    localparam logic [6:0] C_AC_L2_START = 7'h40;
    localparam logic [6:0] C_AC_L2_END   = 7'h67;

    localparam int unsigned C_DDRAM_DEPTH = 32;
    localparam logic [7:0]  C_BLANK       = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // {valid, index}: only the 16 visible columns of each line are stored.
    function automatic logic [5:0] ac_to_index(input logic [6:0] ac);
        logic [5:0] r;
        if (ac[6:4] == 3'b000)
            r = {1'b1, 1'b0, ac[3:0]};
        else if (ac[6:4] == 3'b100)
            r = {1'b1, 1'b1, ac[3:0]};
        else
            r = 6'd0;
        return r;
    endfunction

    // One address-counter step with two-line wrap. Addresses in the gaps
    // between lines (reachable only via set-address) fold onto the nearest
    // legal address on their next step.
    function automatic logic [6:0] ac_next(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (inc) begin
            if (a >= C_AC_L1_END && a < C_AC_L2_START)
                n = C_AC_L2_START;
            else if (a >= C_AC_L2_END)
                n = 7'h00;
            else
                n = a + 7'd1;
        end else begin
            if (a == 7'h00)
                n = C_AC_L2_END;
            else if (a > C_AC_L1_END && a <= C_AC_L2_START)
                n = C_AC_L1_END;
            else if (a > C_AC_L2_END)
                n = C_AC_L2_END;
            else
                n = a - 7'd1;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddram_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : ddram_buffer
//  Purpose  : 32 x 8 display data store, reset to blanks (0x20).
//  Ports    : clk, reset           - clock, synchronous active-high reset
//             we_i/waddr_i/wdata_i - single write port
//             raddr_i/rdata_o      - synchronous read (1-cycle latency,
//                                    returns old data on same-cycle write)
//             caddr_i/cdata_o      - combinational read
//  Revision : 1.0  initial release
// ============================================================================
module ddram_buffer
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we_i,
    input  logic [4:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [4:0] raddr_i,
    output logic [7:0] rdata_o,
    input  logic [4:0] caddr_i,
    output logic [7:0] cdata_o
);

    logic [7:0] mem_q [C_DDRAM_DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < C_DDRAM_DEPTH; i++)
                mem_q[i] <= C_BLANK;
            rdata_q <= C_BLANK;
        end else begin
            if (we_i)
                mem_q[waddr_i] <= wdata_i;
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
    assign cdata_o = mem_q[caddr_i];

endmodule
`default_nettype wire

// File: rtl/lcd_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_bus_responder
//  Purpose  : Responder side of an HD44780-style 8-bit LCD bus. Decodes
//             accesses on the falling edge of e, keeps a 2x16 DDRAM image,
//             models busy flag / execution time and flags bus violations.
//  Ports    : clk, reset            - 50 MHz clock, sync active-high reset
//             e, rs, rw, data_in    - bus from the driver
//             data_out, data_oe     - read data and its drive enable
//             rd_addr, rd_char      - debug readout of DDRAM (1-cycle latency)
//             busy_flag, ac         - busy flag and address counter
//             disp_on               - display-on bit
//             protocol_err          - sticky violation flag
//  Revision : 1.0  initial release
// ============================================================================
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int unsigned CYCLES_1530US = C_CYCLES_1530US,
    parameter int unsigned CYCLES_43US   = C_CYCLES_43US,
    parameter int unsigned CYCLES_39US   = C_CYCLES_39US,
    parameter int unsigned CYCLES_E_MIN  = C_CYCLES_E_MIN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       busy_flag,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       protocol_err
);

    localparam int unsigned MAX_CYC =
        (CYCLES_1530US > CYCLES_43US) ?
            ((CYCLES_1530US > CYCLES_39US) ? CYCLES_1530US : CYCLES_39US) :
            ((CYCLES_43US   > CYCLES_39US) ? CYCLES_43US   : CYCLES_39US);
    localparam int          CNT_W  = $clog2(MAX_CYC + 1);
    localparam logic [7:0]  E_MIN  = 8'(CYCLES_E_MIN);

    // Bus sampling
    logic       e_q, rs_q, rw_q;
    logic [7:0] data_q;
    logic [7:0] ew_q;           // e-high width, saturating

    // Execution state
    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               clr_pend_q;
    logic [4:0]         clr_idx_q;
    logic               busy_q;
    logic [6:0]         ac_q;
    logic               id_q;
    logic               disp_q;
    logic               err_q;

    // Access classification at the falling edge of e
    logic w_fall, w_long, w_commit, w_bf_read, w_do, w_dr_wr;
    assign w_fall    = e_q & ~e;
    assign w_long    = (ew_q >= E_MIN);
    assign w_commit  = w_fall & w_long;
    assign w_bf_read = w_commit & ~rs_q & rw_q;
    assign w_do      = w_commit & ~w_bf_read & ~busy_q;
    assign w_dr_wr   = w_do & rs_q & ~rw_q;

    logic [5:0] w_map;
    logic       w_valid;
    logic [4:0] w_idx;
    assign w_map   = ac_to_index(ac_q);
    assign w_valid = w_map[5];
    assign w_idx   = w_map[4:0];

    // DDRAM write port: the clear fill and a DR write can never coincide,
    // because a DR write is only accepted when not busy.
    logic       w_we;
    logic [4:0] w_waddr;
    logic [7:0] w_wdata;
    logic [7:0] w_cdata;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_idx;
        w_wdata = data_q;
        if (state_q == ST_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = clr_idx_q;
            w_wdata = C_BLANK;
        end else if (w_dr_wr && w_valid) begin
            w_we    = 1'b1;
        end
    end

    ddram_buffer u_ddram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (w_we),
        .waddr_i (w_waddr),
        .wdata_i (w_wdata),
        .raddr_i (rd_addr),
        .rdata_o (rd_char),
        .caddr_i (w_idx),
        .cdata_o (w_cdata)
    );

    // Read data follows the registered strobe so it is stable for the whole
    // high phase; off-screen DR reads return a blank.
    logic [7:0] w_dr_rdata;
    assign w_dr_rdata = w_valid ? w_cdata : C_BLANK;
    assign data_oe    = e_q & rw_q;
    assign data_out   = !data_oe ? 8'h00 : (rs_q ? w_dr_rdata : {busy_q, ac_q});

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
            rw_q       <= 1'b0;
            data_q     <= 8'h00;
            ew_q       <= 8'd0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            clr_pend_q <= 1'b0;
            clr_idx_q  <= 5'd0;
            busy_q     <= 1'b0;
            ac_q       <= 7'h00;
            id_q       <= 1'b1;
            disp_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            e_q    <= e;
            rs_q   <= rs;
            rw_q   <= rw;
            data_q <= data_in;
            ew_q   <= e ? ((ew_q == 8'hFF) ? ew_q : ew_q + 8'd1) : 8'd0;

            // Runt strobe, or a non-status access while executing.
            if (w_fall && !w_long)
                err_q <= 1'b1;
            else if (w_commit && !w_bf_read && busy_q)
                err_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (w_do) begin
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                        if (rs_q) begin
                            // DR read or write: ac steps either way.
                            ac_q  <= ac_next(ac_q, id_q);
                            cnt_q <= CNT_W'(CYCLES_43US);
                        end else begin
                            cnt_q <= CNT_W'(CYCLES_39US);
                            if (data_q == CMD_CLEAR) begin
                                ac_q       <= 7'h00;
                                id_q       <= 1'b1;
                                clr_pend_q <= 1'b1;
                                cnt_q      <= CNT_W'(CYCLES_1530US);
                            end else if (data_q[7:1] == 7'b0000001) begin
                                ac_q  <= 7'h00;
                                cnt_q <= CNT_W'(CYCLES_1530US);
                            end else if (data_q[7:2] == 6'b000001) begin
                                // Display shift (S) has no visible effect here.
                                id_q <= data_q[1];
                            end else if (data_q[7:3] == 5'b00001) begin
                                // Cursor and blink are not rendered.
                                disp_q <= data_q[2];
                            end else if (data_q[7:4] == 4'b0001) begin
                                if (!data_q[3])
                                    ac_q <= ac_next(ac_q, data_q[2]);
                            end else if (data_q[7:5] == 3'b001) begin
                                if (!data_q[4] || !data_q[3])
                                    err_q <= 1'b1;
                            end else if (data_q[7]) begin
                                ac_q <= data_q[6:0];
                            end
                            // CGRAM address and 0x00 fall through as timed no-ops.
                        end
                    end
                end

                ST_EXEC: begin
                    if (clr_pend_q) begin
                        state_q    <= ST_CLEAR;
                        clr_pend_q <= 1'b0;
                        clr_idx_q  <= 5'd0;
                        cnt_q      <= cnt_q - CNT_W'(1);
                    end else if (cnt_q <= CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                ST_CLEAR: begin
                    // Busy count keeps running while the fill walks DDRAM.
                    if (cnt_q > CNT_W'(1))
                        cnt_q <= cnt_q - CNT_W'(1);
                    clr_idx_q <= clr_idx_q + 5'd1;
                    if (clr_idx_q == 5'd31)
                        state_q <= ST_EXEC;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_flag    = busy_q;
    assign ac           = ac_q;
    assign disp_on      = disp_q;
    assign protocol_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcd_bus_responder
//  Purpose  : Directed self-checking bench for lcd_bus_responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lcd_bus_responder;
    import lcd_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       e, rs, rw;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic       busy_flag;
    logic [6:0] ac;
    logic       disp_on;
    logic       protocol_err;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    // Clear/home shortened so the whole run stays short.
    lcd_bus_responder #(
        .CYCLES_1530US (300),
        .CYCLES_43US   (2150),
        .CYCLES_39US   (1950),
        .CYCLES_E_MIN  (7)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .e            (e),
        .rs           (rs),
        .rw           (rw),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_oe      (data_oe),
        .rd_addr      (rd_addr),
        .rd_char      (rd_char),
        .busy_flag    (busy_flag),
        .ac           (ac),
        .disp_on      (disp_on),
        .protocol_err (protocol_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full access: e high for 'width' cycles, then one cycle for the commit.
    task automatic access(input logic r_s, input logic r_w, input logic [7:0] d, input int width);
        rs      = r_s;
        rw      = r_w;
        data_in = d;
        e       = 1'b1;
        repeat (width) tick();
        e = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string tag, output int cycles);
        cycles = 0;
        while (busy_flag && cycles < 5000) begin
            tick();
            cycles++;
        end
        check(tag, 32'(busy_flag), 32'h0);
    endtask

    task automatic read_entry(input string tag, input int idx, input logic [7:0] exp);
        rd_addr = idx[4:0];
        tick();
        check(tag, 32'(rd_char), 32'(exp));
    endtask

    task automatic ir(input logic [7:0] d);
        access(1'b0, 1'b0, d, 10);
        wait_idle("ir_idle", n);
    endtask

    task automatic dw(input logic [7:0] d);
        access(1'b1, 1'b0, d, 10);
        wait_idle("dw_idle", n);
    endtask

    initial begin
        reset = 1'b1; e = 1'b0; rs = 1'b0; rw = 1'b0; data_in = 8'h00; rd_addr = 5'd0;
        tick();
        tick();
        check("rst_busy",    32'(busy_flag),    32'h0);
        check("rst_ac",      32'(ac),           32'h0);
        check("rst_disp",    32'(disp_on),      32'h0);
        check("rst_err",     32'(protocol_err), 32'h0);
        check("rst_oe",      32'(data_oe),      32'h0);
        check("rst_dout",    32'(data_out),     32'h0);
        check("rst_rd_char", 32'(rd_char),      32'h20);
        reset = 1'b0;
        tick();

        // Function set 0x38: busy one cycle after fall, for exactly 1950 cycles.
        rs = 1'b0; rw = 1'b0; data_in = 8'h38; e = 1'b1;
        repeat (10) tick();
        e = 1'b0;
        check("busy_before_commit", 32'(busy_flag), 32'h0);
        tick();
        check("busy_after_fall", 32'(busy_flag), 32'h1);
        repeat (1949) tick();
        check("busy_last_cycle", 32'(busy_flag), 32'h1);
        tick();
        check("busy_end_1950", 32'(busy_flag), 32'h0);
        check("fset38_err", 32'(protocol_err), 32'h0);

        // Entry mode, address 0, two data writes.
        access(1'b0, 1'b0, 8'h06, 10);
        wait_idle("entry_idle", n);
        check("entry_time", 32'(n), 32'd1950);
        ir(8'h80);
        access(1'b1, 1'b0, 8'h31, 10);
        wait_idle("dw31_idle", n);
        check("dr_wr_time", 32'(n), 32'd2150);
        dw(8'h32);
        read_entry("ddram0_31", 0, 8'h31);
        read_entry("ddram1_32", 1, 8'h32);
        check("ac_after_2wr", 32'(ac), 32'h02);

        // Line-end wraps and off-screen writes.
        ir(8'hA7);
        check("ac_set_27", 32'(ac), 32'h27);
        dw(8'h41);
        check("ac_wrap_27_40", 32'(ac), 32'h40);
        read_entry("offscreen_dropped", 7, 8'h20);
        ir(8'hCF);
        dw(8'h42);
        read_entry("ddram31_42", 31, 8'h42);
        check("ac_4f_to_50", 32'(ac), 32'h50);
        ir(8'hE7);
        dw(8'h43);
        check("ac_wrap_67_00", 32'(ac), 32'h00);

        // Decrement mode and cursor shifts.
        ir(8'h04);
        ir(8'hC0);
        dw(8'h45);
        read_entry("ddram16_45", 16, 8'h45);
        check("ac_dec_40_27", 32'(ac), 32'h27);
        ir(8'h14);
        check("shift_right_27_40", 32'(ac), 32'h40);
        ir(8'h10);
        check("shift_left_40_27", 32'(ac), 32'h27);
        ir(8'h80);
        dw(8'h44);
        read_entry("ddram0_44", 0, 8'h44);
        check("ac_dec_00_67", 32'(ac), 32'h67);
        ir(8'h06);

        // DR read of entry 31.
        ir(8'hCF);
        rs = 1'b1; rw = 1'b1; e = 1'b1;
        repeat (8) tick();
        check("dr_read_oe",   32'(data_oe),  32'h1);
        check("dr_read_data", 32'(data_out), 32'h42);
        e = 1'b0;
        tick();
        check("dr_read_ac_step", 32'(ac),      32'h50);
        check("dr_read_oe_off",  32'(data_oe), 32'h0);
        wait_idle("dr_read_idle", n);
        check("dr_read_time", 32'(n), 32'd2150);
        ir(8'h0C);
        check("disp_on_set", 32'(disp_on), 32'h1);
        check("no_err_yet",  32'(protocol_err), 32'h0);

        // Clear display, status read and illegal write while busy.
        access(1'b0, 1'b0, 8'h01, 10);
        check("clear_busy", 32'(busy_flag), 32'h1);
        check("clear_ac",   32'(ac),        32'h0);
        rs = 1'b0; rw = 1'b1; e = 1'b1;
        repeat (8) tick();
        check("status_oe",   32'(data_oe),  32'h1);
        check("status_data", 32'(data_out), 32'h80);
        e = 1'b0;
        tick();
        check("status_no_err", 32'(protocol_err), 32'h0);
        access(1'b1, 1'b0, 8'h55, 8);
        check("busy_write_err", 32'(protocol_err), 32'h1);
        wait_idle("clear_idle", n);
        for (int i = 0; i < 32; i++)
            read_entry("clear_entry", i, 8'h20);
        check("clear_ac_final", 32'(ac), 32'h0);

        // Runt e pulse.
        reset = 1'b1; tick(); reset = 1'b0; tick();
        ir(8'h85);
        check("ac_set_05", 32'(ac), 32'h05);
        access(1'b0, 1'b0, 8'h80, 4);
        check("runt_err",  32'(protocol_err), 32'h1);
        check("runt_ac",   32'(ac),           32'h05);
        check("runt_busy", 32'(busy_flag),    32'h0);

        // Unsupported function set.
        reset = 1'b1; tick(); reset = 1'b0; tick();
        ir(8'h28);
        check("fset28_err", 32'(protocol_err), 32'h1);

        // Reset during the clear fill.
        reset = 1'b1; tick(); reset = 1'b0; tick();
        ir(8'h80);
        dw(8'h5A);
        ir(8'h0C);
        read_entry("pre_clear_5a", 0, 8'h5A);
        check("pre_clear_disp", 32'(disp_on),      32'h1);
        check("pre_clear_err",  32'(protocol_err), 32'h0);
        access(1'b0, 1'b0, 8'h01, 10);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("abort_busy", 32'(busy_flag),    32'h0);
        check("abort_ac",   32'(ac),           32'h0);
        check("abort_disp", 32'(disp_on),      32'h0);
        check("abort_err",  32'(protocol_err), 32'h0);
        reset = 1'b0;
        tick();
        check("abort_busy_after", 32'(busy_flag), 32'h0);
        for (int i = 0; i < 32; i++)
            read_entry("abort_entry", i, 8'h20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
